// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape and baud divider.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int CNT_W     = 13;

  function automatic int baud_div(
    input int clk_hz,
    input int bps
  );
    return clk_hz / bps;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver pin and byte-output bundle.
// master = the receiver, slave = the line driver and byte consumer.
interface uart_rx_if;

  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rx,
    output po_data,
    output po_flag,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx,
    input  po_data,
    input  po_flag,
    input  frame_err,
    input  rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pin plus falling-edge detect.
// Edges are only reported once the pin has been seen high since reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s2,
  output logic fall
);

  logic       rx_s1;
  logic       rx_s3;
  logic [1:0] warm;
  logic       primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_s3  <= 1'b1;
      warm   <= 2'b00;
      primed <= 1'b0;
    end else begin
      rx_s1  <= rx;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
      warm   <= {warm[0], 1'b1};
      // rx_s2 holds real pin data only once warm[1] is set
      if (warm[1] && rx_s2)
        primed <= 1'b1;
    end
  end

  assign fall = primed & rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start detect, mid-bit sampling,
// one-cycle po_flag on a good byte, frame_err on a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_BPS = 9600,
  parameter int CLK      = 50_000_000
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int BAUD_CNT_MAX = baud_div(CLK, UART_BPS);
  localparam int HALF_CNT     = BAUD_CNT_MAX / 2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] SAMP = CNT_W'(HALF_CNT - 1);
  localparam logic [2:0]       TOPB = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             rx_s2;
  logic             fall;
  logic             samp;
  logic             last;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rx    (bus.rx),
    .rx_s2 (rx_s2),
    .fall  (fall)
  );

  assign samp = (baud_cnt == SAMP);
  assign last = (baud_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      bus.po_data   <= 8'h00;
      bus.po_flag   <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.rx_busy   <= 1'b0;
    end else begin
      bus.po_flag   <= 1'b0;
      bus.frame_err <= 1'b0;
      if (state == IDLE || last)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (fall) begin
            state       <= START;
            bus.rx_busy <= 1'b1;
          end
        end
        START: begin
          if (samp && rx_s2) begin
            state       <= IDLE;
            bus.rx_busy <= 1'b0;
          end else if (last) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (samp)
            shift <= {rx_s2, shift[7:1]};
          if (last) begin
            if (bit_cnt == TOPB)
              state <= STOP;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          // leave at mid stop bit so a back-to-back start is caught
          if (samp) begin
            state       <= IDLE;
            bus.rx_busy <= 1'b0;
            if (rx_s2) begin
              bus.po_data <= shift;
              bus.po_flag <= 1'b1;
            end else begin
              bus.frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a scoreboard of expected bytes.
// Runs at 16 clocks per bit to keep frames short.
module tb_uart_rx;

  localparam int BIT  = 16;
  localparam int HALF = BIT / 2;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_flag = 0;
  int   n_err = 0;

  exp_t exp_q[$];
  int   flag_t[$];

  uart_rx_if bus ();

  uart_rx #(
    .UART_BPS (10),
    .CLK      (160)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.po_flag || bus.frame_err)) begin
      exp_t e;
      chk("excl", 32'(bus.po_flag & bus.frame_err), 0);
      if (bus.po_flag) begin
        n_flag++;
        flag_t.push_back(cyc);
      end
      if (bus.frame_err)
        n_err++;
      if (exp_q.size() == 0) begin
        chk("unexpected", {bus.po_flag, bus.frame_err}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("kind", 32'(bus.frame_err), 32'(e.err));
        chk("data", 32'(bus.po_data), 32'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stp);
    logic [9:0] fr;
    fr = {stp, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = fr[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic expect_b(input logic [7:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_e(input logic [7:0] held);
    exp_t e;
    e.err  = 1'b1;
    e.data = held;
    exp_q.push_back(e);
  endtask

  initial begin
    int c0;
    int d;
    // reset with line held low
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(bus.po_data), 0);
    chk("rst_flag", 32'(bus.po_flag), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
    chk("rst_busy", 32'(bus.rx_busy), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("stuck_low_busy", 32'(bus.rx_busy), 0);
    idle(20);

    // single frame and latency
    expect_b(8'h55);
    c0 = cyc;
    send(8'h55, 1'b1);
    chk("busy_after", 32'(bus.rx_busy), 0);
    d = flag_t[$] - c0;
    if (d >= 154 && d <= 156) d = 155;
    chk("latency", 32'(d), 155);
    idle(20);

    // back-to-back, no idle gap
    expect_b(8'hA5);
    expect_b(8'h3C);
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    idle(8);
    d = flag_t[$] - flag_t[$-1];
    if (d >= 10*BIT-2 && d <= 10*BIT+2) d = 10*BIT;
    chk("b2b_gap", 32'(d), 32'(10*BIT));
    idle(20);

    // short glitch is a false start
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy", 32'(bus.rx_busy), 1);
    repeat (HALF + 12) @(negedge clk);
    chk("glitch_idle", 32'(bus.rx_busy), 0);
    idle(20);

    // low stop bit discards the byte
    expect_b(8'h11);
    send(8'h11, 1'b1);
    expect_e(8'h11);
    send(8'h7E, 1'b0);
    idle(32);
    chk("held_data", 32'(bus.po_data), 32'h11);
    expect_b(8'hC3);
    send(8'hC3, 1'b1);
    idle(20);

    // async reset mid-DATA of 0xFF
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3*BIT) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(bus.po_data), 0);
    chk("mid_rst_busy", 32'(bus.rx_busy), 0);
    chk("mid_rst_flag", 32'(bus.po_flag), 0);
    chk("mid_rst_ferr", 32'(bus.frame_err), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(6*BIT);
    expect_b(8'h81);
    send(8'h81, 1'b1);
    idle(20);

    // transmitter-style stream
    expect_b(8'h00);
    expect_b(8'hFF);
    expect_b(8'h5A);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h5A, 1'b1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++)
      @(negedge clk);
    idle(20);
    chk("pending", 32'(exp_q.size()), 0);
    chk("n_flag", 32'(n_flag), 9);
    chk("n_err", 32'(n_err), 1);
    chk("last_data", 32'(bus.po_data), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
